// File: rtl/risc_pkg.sv
// Shared fetch/decode constants and the instruction word type.
package risc_pkg;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0000;

  typedef logic [DW-1:0] instr_t;

  // Sequential successor of a PC; wraps modulo 2^AW.
  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] pc);
    return pc + AW'(1);
  endfunction

endpackage

// File: rtl/risc_sync_fifo.sv
// Prefetch queue storage: DEPTH x W synchronous FIFO with flush-style clear.
module risc_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 40
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  input  logic                   clear,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full queue may still accept.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (!reset)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/risc_fetch_queue.sv
// Fetch stage: issues PC reads to a one-cycle instruction memory and queues
// returned words for decode; stalls the PC mux by returning PC_1 == PC.
module risc_fetch_queue
  import risc_pkg::*;
#(
  parameter int            DEPTH = 2,
  parameter int            AW    = risc_pkg::AW,
  parameter int            DW    = risc_pkg::DW,
  parameter logic [DW-1:0] NOP   = risc_pkg::NOP
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [AW-1:0] PC,
  input  logic          branch_predict,
  output logic [AW-1:0] imem_addr,
  output logic          imem_rd,
  input  logic [DW-1:0] imem_rdata,
  input  logic          dc_ready,
  output logic [DW-1:0] IR,
  output logic [AW-1:0] IR_PC_1,
  output logic          ir_valid,
  output logic [AW-1:0] PC_1
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DW + AW;

  logic [CW-1:0] count;
  logic [CW-1:0] occupancy;
  logic [EW-1:0] head;
  logic          inflight_p1;
  logic [AW-1:0] tag_p1;
  logic          flush;
  logic          push;
  logic          pop;
  logic          can_issue;

  assign flush    = ~branch_predict;
  assign ir_valid = (count != '0);
  assign push     = inflight_p1 & ~flush;
  assign pop      = ir_valid & dc_ready & ~flush;

  // Slots committed after this edge; crediting the pop keeps streaming at one
  // instruction per cycle. Never underflows: pop implies count >= 1.
  assign occupancy = count + CW'(inflight_p1) - CW'(pop);
  assign can_issue = reset & branch_predict & (occupancy < CW'(DEPTH));

  assign imem_addr = PC;
  assign imem_rd   = can_issue;
  assign PC_1      = can_issue ? PC + AW'(1) : PC;

  // Stage p0 -> p1: read issued, response and its tag land next edge.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) inflight_p1 <= 1'b0;
    else        inflight_p1 <= can_issue;
  end

  always_ff @(posedge CLK) begin
    if (can_issue) tag_p1 <= PC_1;
  end

  // Stage p1 -> queue: response pushed with its tag unless flushed.
  risc_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_queue (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .wdata ({imem_rdata, tag_p1}),
    .pop   (pop),
    .clear (flush),
    .rdata (head),
    .count (count)
  );

  assign IR      = ir_valid ? head[EW-1:AW] : NOP;
  assign IR_PC_1 = ir_valid ? head[AW-1:0]  : '0;

  a_full_no_inflight: assert property (@(posedge CLK) disable iff (!reset)
    (count == CW'(DEPTH)) |-> !inflight_p1);

endmodule

// File: tb/tb_risc_fetch_queue.sv
// Directed, table-driven bench for the fetch queue with a one-cycle memory model.
module tb_risc_fetch_queue;

  logic        CLK;
  logic        reset;
  logic [7:0]  PC;
  logic        branch_predict;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [31:0] imem_rdata = '0;
  logic        dc_ready;
  logic [31:0] IR;
  logic [7:0]  IR_PC_1;
  logic        ir_valid;
  logic [7:0]  PC_1;

  int checks = 0;
  int errors = 0;

  risc_fetch_queue #(.DEPTH(2), .AW(8), .DW(32), .NOP(32'h0)) dut (
    .CLK            (CLK),
    .reset          (reset),
    .PC             (PC),
    .branch_predict (branch_predict),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .imem_rdata     (imem_rdata),
    .dc_ready       (dc_ready),
    .IR             (IR),
    .IR_PC_1        (IR_PC_1),
    .ir_valid       (ir_valid),
    .PC_1           (PC_1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: word at addr is A000_0000 + addr, one cycle after read.
  always @(posedge CLK) begin
    if (imem_rd) imem_rdata <= 32'hA000_0000 + {24'h0, imem_addr};
  end

  typedef struct {
    logic        rst;
    logic [7:0]  pc;
    logic        bp;
    logic        rdy;
    logic        e_rd;
    logic [7:0]  e_pc1;
    logic        e_v;
    logic [31:0] e_ir;
    logic [7:0]  e_irpc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [7:0] pc, input logic bp,
                     input logic rdy, input logic e_rd, input logic [7:0] e_pc1,
                     input logic e_v, input logic [31:0] e_ir, input logic [7:0] e_irpc);
    vq.push_back('{rst, pc, bp, rdy, e_rd, e_pc1, e_v, e_ir, e_irpc});
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): actual %h required %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic e_rd,
                            input logic [7:0] e_pc1, input logic e_v,
                            input logic [31:0] e_ir, input logic [7:0] e_irpc);
    chk({tag, ".imem_rd"},  idx, {31'h0, imem_rd},  {31'h0, e_rd});
    chk({tag, ".PC_1"},     idx, {24'h0, PC_1},     {24'h0, e_pc1});
    chk({tag, ".ir_valid"}, idx, {31'h0, ir_valid}, {31'h0, e_v});
    chk({tag, ".IR"},       idx, IR,                e_ir);
    chk({tag, ".IR_PC_1"},  idx, {24'h0, IR_PC_1},  {24'h0, e_irpc});
  endtask

  initial begin
    reset          = 1'b0;
    PC             = 8'h10;
    branch_predict = 1'b1;
    dc_ready       = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    check_outs("reset", 0, 1'b0, 8'h10, 1'b0, 32'h0, 8'h00);
    reset = 1'b1;
    #1;
    chk("reset.imem_addr", 1, {24'h0, imem_addr}, 32'h10);
    check_outs("release", 1, 1'b1, 8'h11, 1'b0, 32'h0, 8'h00);

    // Streaming, dc_ready=1
    add(1, 8'h00, 1, 1, 1, 8'h01, 0, 32'h0,         8'h00);
    add(0, 8'h01, 1, 1, 1, 8'h02, 0, 32'h0,         8'h00);
    add(0, 8'h02, 1, 1, 1, 8'h03, 1, 32'hA000_0000, 8'h01);
    add(0, 8'h03, 1, 1, 1, 8'h04, 1, 32'hA000_0001, 8'h02);
    add(0, 8'h04, 1, 1, 1, 8'h05, 1, 32'hA000_0002, 8'h03);
    add(0, 8'h05, 1, 1, 1, 8'h06, 1, 32'hA000_0003, 8'h04);
    add(0, 8'h06, 1, 1, 1, 8'h07, 1, 32'hA000_0004, 8'h05);
    add(0, 8'h07, 1, 1, 1, 8'h08, 1, 32'hA000_0005, 8'h06);
    // Backpressure then release
    add(1, 8'h00, 1, 0, 1, 8'h01, 0, 32'h0,         8'h00);
    add(0, 8'h01, 1, 0, 1, 8'h02, 0, 32'h0,         8'h00);
    add(0, 8'h02, 1, 0, 0, 8'h02, 1, 32'hA000_0000, 8'h01);
    add(0, 8'h02, 1, 0, 0, 8'h02, 1, 32'hA000_0000, 8'h01);
    add(0, 8'h02, 1, 1, 1, 8'h03, 1, 32'hA000_0000, 8'h01);
    add(0, 8'h03, 1, 1, 1, 8'h04, 1, 32'hA000_0001, 8'h02);
    add(0, 8'h04, 1, 1, 1, 8'h05, 1, 32'hA000_0002, 8'h03);
    add(0, 8'h05, 1, 1, 1, 8'h06, 1, 32'hA000_0003, 8'h04);
    // Flush with one entry queued and a read in flight, redirect to 0x40
    add(1, 8'h00, 1, 0, 1, 8'h01, 0, 32'h0,         8'h00);
    add(0, 8'h01, 1, 0, 1, 8'h02, 0, 32'h0,         8'h00);
    add(0, 8'h02, 0, 0, 0, 8'h02, 1, 32'hA000_0000, 8'h01);
    add(0, 8'h40, 1, 1, 1, 8'h41, 0, 32'h0,         8'h00);
    add(0, 8'h41, 1, 1, 1, 8'h42, 0, 32'h0,         8'h00);
    add(0, 8'h42, 1, 1, 1, 8'h43, 1, 32'hA000_0040, 8'h41);
    add(0, 8'h43, 1, 1, 1, 8'h44, 1, 32'hA000_0041, 8'h42);
    // PC wrap at 0xFF
    add(1, 8'hFE, 1, 1, 1, 8'hFF, 0, 32'h0,         8'h00);
    add(0, 8'hFF, 1, 1, 1, 8'h00, 0, 32'h0,         8'h00);
    add(0, 8'h00, 1, 1, 1, 8'h01, 1, 32'hA000_00FE, 8'hFF);
    add(0, 8'h01, 1, 1, 1, 8'h02, 1, 32'hA000_00FF, 8'h00);
    // Setup for async reset: one entry queued, one read in flight
    add(1, 8'h00, 1, 0, 1, 8'h01, 0, 32'h0,         8'h00);
    add(0, 8'h01, 1, 0, 1, 8'h02, 0, 32'h0,         8'h00);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge CLK);
      if (vq[i].rst) begin
        reset = 1'b0;
        #1;
        reset = 1'b1;
      end
      PC             = vq[i].pc;
      branch_predict = vq[i].bp;
      dc_ready       = vq[i].rdy;
      #1;
      chk("vec.imem_addr", i, {24'h0, imem_addr}, {24'h0, vq[i].pc});
      check_outs("vec", i, vq[i].e_rd, vq[i].e_pc1, vq[i].e_v, vq[i].e_ir, vq[i].e_irpc);
    end

    // Async reset between edges with count=1 and a read in flight
    @(negedge CLK);
    PC = 8'h02;
    #1;
    check_outs("pre_arst", 0, 1'b0, 8'h02, 1'b1, 32'hA000_0000, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    check_outs("arst", 0, 1'b0, 8'h02, 1'b0, 32'h0, 8'h00);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check_outs("arst_rel", 0, 1'b1, 8'h03, 1'b0, 32'h0, 8'h00);
    @(negedge CLK);
    PC = 8'h03;
    #1;
    check_outs("arst_rel", 1, 1'b1, 8'h04, 1'b0, 32'h0, 8'h00);
    @(negedge CLK);
    PC = 8'h04;
    #1;
    check_outs("arst_rel", 2, 1'b0, 8'h04, 1'b1, 32'hA000_0002, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
